// File: rtl/pwm_pkg.sv
// ============================================================================
//  Module      : pwm_pkg
//  Description : Constants and types shared by the PWM generator and the
//                PWM capture block, so both sides agree on period and
//                duty-cycle width.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

    // Generator counter wrap; the capture side expects exactly this period
    localparam int PWM_PERIOD = 256;

    // Width of the duty-cycle word on both sides
    localparam int DUTY_W = 8;

    typedef logic [DUTY_W-1:0] duty_t;

    // Capture FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MEAS = 1'b1;

endpackage : pwm_pkg

`default_nettype wire

// File: rtl/pwm_capture_if.sv
// ============================================================================
//  Module      : pwm_capture_if
//  Description : Bundle between the PWM capture block and its consumer.
//                master = capture block (drives measurement results),
//                slave  = consumer / stimulus side (drives pwm_in).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pwm_capture_if
    import pwm_pkg::*;
#(
    parameter int CNT_W = 16
);

    logic               pwm_in;
    duty_t              duty_cycle;
    logic [CNT_W-1:0]   high_cnt;
    logic [CNT_W-1:0]   period_cnt;
    logic               valid;
    logic               period_err;
    logic               stuck;

    modport master (
        input  pwm_in,
        output duty_cycle,
        output high_cnt,
        output period_cnt,
        output valid,
        output period_err,
        output stuck
    );

    modport slave (
        output pwm_in,
        input  duty_cycle,
        input  high_cnt,
        input  period_cnt,
        input  valid,
        input  period_err,
        input  stuck
    );

endinterface : pwm_capture_if

`default_nettype wire

// File: rtl/pwm_capture_sync.sv
// ============================================================================
//  Module      : pwm_sync
//  Description : Two-flop synchronizer for the asynchronous PWM input,
//                followed by a one-cycle delayed copy used for edge
//                detection. Outputs the synchronized level plus single-cycle
//                rise and fall strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_sync (
    input  wire logic clk,
    input  wire logic reset,     // asynchronous, active-low
    input  wire logic i_pwm,
    output logic      o_level,
    output logic      o_rise,
    output logic      o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_prev;

    // Metastability filter on the raw input plus previous-level register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= i_pwm;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_prev;
    assign o_fall  = ~r_s2 & r_prev;

endmodule : pwm_sync

`default_nettype wire

// File: rtl/pwm_capture.sv
// ============================================================================
//  Module      : pwm_capture
//  Description : Measures high time and period of an asynchronous PWM
//                waveform, reconstructs the generator duty value, flags
//                off-period cycles and detects a stuck (0 % / 100 %) line.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_capture
    import pwm_pkg::*;
#(
    parameter int PERIOD  = PWM_PERIOD,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  wire logic       clk,
    input  wire logic       reset,   // asynchronous, active-low
    pwm_capture_if.master   bus
);

    localparam int               IDLE_W      = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] c_IDLE_MAX  = IDLE_W'(TIMEOUT);
    localparam logic [IDLE_W-1:0] c_IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] c_IDLE_ONE  = IDLE_W'(1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  c_PERIOD    = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0]  c_DUTY_MAX  = CNT_W'((1 << DUTY_W) - 1);

    // ------------------------------------------------------------------
    // Synchronizer / edge detector
    // ------------------------------------------------------------------
    logic w_level;
    logic w_rise;
    logic w_fall;
    logic w_edge;

    pwm_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_pwm   (bus.pwm_in),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_edge = w_rise | w_fall;

    // ------------------------------------------------------------------
    // Idle (edge-free) counter and timeout detection
    // ------------------------------------------------------------------
    logic [IDLE_W-1:0] r_idle;
    logic              w_timeout;

    // An edge in the same cycle as the would-be timeout suppresses it,
    // and once saturated the counter can never re-trigger the event.
    assign w_timeout = !w_edge && (r_idle == c_IDLE_LAST);

    // Count edge-free cycles, restart on any edge, saturate at TIMEOUT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idle <= '0;
        end else if (w_edge) begin
            r_idle <= '0;
        end else if (r_idle != c_IDLE_MAX) begin
            r_idle <= r_idle + c_IDLE_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------
    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic       w_load;      // start a new measurement window
    logic       w_capture;   // close the current window into the outputs
    logic       w_count;     // advance the running counters
    logic       w_clear;     // abandon measurement after a stuck line

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: a rise opens/continues measurement, a timeout abandons it
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_MEAS;
                end
            end
            ST_MEAS: begin
                if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Control strobes decoded from state and edge events
    always_comb begin
        w_load    = 1'b0;
        w_capture = 1'b0;
        w_count   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load = w_rise;
            end
            ST_MEAS: begin
                w_load    = w_rise;
                w_capture = w_rise;
                w_count   = !w_rise && !w_timeout;
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    assign w_clear = w_timeout;

    // ------------------------------------------------------------------
    // Period and high-time counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_per;
    logic [CNT_W-1:0] r_high;

    // Running counters; the rise cycle itself is counted as 1 (high)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_per  <= '0;
            r_high <= '0;
        end else if (w_clear) begin
            r_per  <= '0;
            r_high <= '0;
        end else if (w_load) begin
            r_per  <= c_CNT_ONE;
            r_high <= c_CNT_ONE;
        end else if (w_count) begin
            if (r_per != c_CNT_MAX) begin
                r_per <= r_per + c_CNT_ONE;
            end
            if (w_level && (r_high != c_CNT_MAX)) begin
                r_high <= r_high + c_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------
    duty_t            r_duty;
    logic [CNT_W-1:0] r_high_cnt;
    logic [CNT_W-1:0] r_period_cnt;
    logic             r_valid;
    logic             r_period_err;
    logic             r_stuck;
    duty_t            w_duty_sat;
    logic             w_per_ok;

    // High time clipped to the largest representable duty value
    assign w_duty_sat = (r_high > c_DUTY_MAX) ? '1 : r_high[DUTY_W-1:0];
    assign w_per_ok   = (r_per == c_PERIOD);

    // Latch a completed window on capture, or report a stuck line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_duty       <= '0;
            r_high_cnt   <= '0;
            r_period_cnt <= '0;
            r_valid      <= 1'b0;
            r_period_err <= 1'b0;
            r_stuck      <= 1'b0;
        end else begin
            r_valid <= w_capture | w_timeout;
            if (w_capture) begin
                r_period_cnt <= r_per;
                r_high_cnt   <= r_high;
                r_period_err <= !w_per_ok;
                if (w_per_ok) begin
                    r_duty <= w_duty_sat;
                end
            end else if (w_timeout) begin
                r_duty       <= w_level ? '1 : '0;
                r_period_err <= 1'b0;
            end

            if (w_timeout) begin
                r_stuck <= 1'b1;
            end else if (w_edge) begin
                r_stuck <= 1'b0;
            end
        end
    end

    assign bus.duty_cycle = r_duty;
    assign bus.high_cnt   = r_high_cnt;
    assign bus.period_cnt = r_period_cnt;
    assign bus.valid      = r_valid;
    assign bus.period_err = r_period_err;
    assign bus.stuck      = r_stuck;

endmodule : pwm_capture

`default_nettype wire

// File: tb/tb_pwm_capture.sv
// ============================================================================
//  Module      : tb_pwm_capture
//  Description : Self-checking bench for pwm_capture. A sample-level
//                reference model turns the driven waveform into expected
//                capture / stuck events; a monitor compares them against
//                every valid pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_capture;

    localparam int P_PERIOD  = 256;
    localparam int P_CNT_W   = 16;
    localparam int P_TIMEOUT = 1024;
    localparam int P_CNT_MAX = (1 << P_CNT_W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    pwm_capture_if #(.CNT_W(P_CNT_W)) bus ();

    pwm_capture #(
        .PERIOD  (P_PERIOD),
        .CNT_W   (P_CNT_W),
        .TIMEOUT (P_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: works on the sequence of input samples. Each sample
    // reaches the edge detector two clocks later; the resulting event is
    // reported on the clock that processes that sample.
    // ------------------------------------------------------------------
    typedef struct {
        int duty;
        int hi;
        int per;
        int perr;
        int stk;
    } exp_t;

    exp_t expq[$];
    bit   pipe[$];
    int   idx, last_edge, rise_idx, hsum;
    bit   lprev, meas;
    int   m_duty, m_hi, m_per, m_perr, m_stuck;

    always @(posedge clk) begin
        bit l, rise, edge_s;
        int per, hi;
        if (!reset) begin
            pipe.delete();
            pipe.push_back(1'b0);
            pipe.push_back(1'b0);
            idx = 0; last_edge = -1; rise_idx = 0; hsum = 0;
            lprev = 1'b0; meas = 1'b0;
            m_duty = 0; m_hi = 0; m_per = 0; m_perr = 0; m_stuck = 0;
            expq.delete();
        end else begin
            pipe.push_back(bus.pwm_in);
            l      = pipe.pop_front();
            rise   = l & ~lprev;
            edge_s = l ^ lprev;
            if (rise) begin
                if (meas) begin
                    per    = idx - rise_idx;
                    hi     = hsum;
                    m_per  = (per > P_CNT_MAX) ? P_CNT_MAX : per;
                    m_hi   = (hi > P_CNT_MAX) ? P_CNT_MAX : hi;
                    m_perr = (m_per != P_PERIOD) ? 1 : 0;
                    if (m_perr == 0) m_duty = (m_hi > 255) ? 255 : m_hi;
                    m_stuck = 0;
                    expq.push_back('{m_duty, m_hi, m_per, m_perr, 0});
                end
                meas     = 1'b1;
                rise_idx = idx;
                hsum     = 1;
            end else if (meas) begin
                hsum += int'(l);
            end
            if (edge_s) begin
                last_edge = idx;
                m_stuck   = 0;
            end else if (idx - last_edge == P_TIMEOUT) begin
                m_stuck = 1;
                m_duty  = l ? 255 : 0;
                m_perr  = 0;
                meas    = 1'b0;
                expq.push_back('{m_duty, m_hi, m_per, m_perr, 1});
            end
            lprev = l;
            idx++;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: pop one expectation per valid pulse
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (bus.valid || expq.size() != 0) begin
                chk("valid", longint'(bus.valid), longint'(expq.size() != 0));
            end
            if (bus.valid && expq.size() != 0) begin
                e = expq.pop_front();
                chk("duty_cycle", longint'(bus.duty_cycle), e.duty);
                chk("high_cnt",   longint'(bus.high_cnt),   e.hi);
                chk("period_cnt", longint'(bus.period_cnt), e.per);
                chk("period_err", longint'(bus.period_err), e.perr);
                chk("stuck@valid", longint'(bus.stuck),     e.stk);
            end
            chk("stuck_level", longint'(bus.stuck), m_stuck);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (always entered on a falling clock edge)
    // ------------------------------------------------------------------
    task automatic hold(input bit lvl, input int n);
        bus.pwm_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic pwm_cycles(input int duty, input int per, input int n);
        for (int k = 0; k < n; k++) begin
            if (duty > 0)   hold(1'b1, duty);
            if (per > duty) hold(1'b0, per - duty);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_duty"},  longint'(bus.duty_cycle), 0);
        chk({tag, "_high"},  longint'(bus.high_cnt),   0);
        chk({tag, "_per"},   longint'(bus.period_cnt), 0);
        chk({tag, "_valid"}, longint'(bus.valid),      0);
        chk({tag, "_perr"},  longint'(bus.period_err), 0);
        chk({tag, "_stuck"}, longint'(bus.stuck),      0);
    endtask

    // Watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pwm_in = 1'b0;
        reset      = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b1;

        // Nominal duty 64, then a mid-run change to 192, then 255
        pwm_cycles(64, P_PERIOD, 6);
        pwm_cycles(192, P_PERIOD, 5);
        pwm_cycles(255, P_PERIOD, 4);

        // Stuck high, then stuck low
        hold(1'b1, 1100);
        hold(1'b0, 1100);

        // Recover, then an off-period waveform (duty must hold at 64)
        pwm_cycles(64, P_PERIOD, 3);
        pwm_cycles(50, 200, 2);
        pwm_cycles(64, P_PERIOD, 2);

        // Asynchronous reset 100 cycles into a duty-64 period
        hold(1'b1, 64);
        hold(1'b0, 36);
        reset = 1'b0;
        #1;
        chk_zero("midreset");
        repeat (5) @(negedge clk);
        reset = 1'b1;
        hold(1'b0, 156);
        pwm_cycles(64, P_PERIOD, 3);

        // Edge landing on the exact timeout cycle: the edge must win
        hold(1'b1, 64);
        hold(1'b0, P_TIMEOUT);
        pwm_cycles(64, P_PERIOD, 2);

        // Randomized duties, mostly at the nominal period
        for (int k = 0; k < 25; k++) begin
            int d, p;
            d = int'($urandom_range(1, 255));
            if ($urandom_range(0, 3) == 0) p = int'($urandom_range(d + 1, 400));
            else                           p = P_PERIOD;
            pwm_cycles(d, p, 1);
        end

        // Close the final window and let the pipeline drain
        hold(1'b1, 8);
        hold(1'b0, 8);
        chk("queue_empty", longint'(expq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pwm_capture

`default_nettype wire

// File: doc/pwm_capture.md
# pwm_capture

Receive-side companion to the `pwm` generator. It samples an asynchronous PWM waveform on `pwm_in` and measures the high time and period of each cycle. It reconstructs the 8-bit `duty_cycle` that produced the waveform, flags cycles with the wrong period, and detects a stuck line (0 % / 100 %). It sits on a board input or loopback path and feeds the duty value back to control or self-test logic.

## Interface
- `PERIOD`, 256: expected PWM period in clk cycles; must match the generator's counter wrap.
- `CNT_W`, 16: width of the high-time and period counters.
- `TIMEOUT`, 1024: edge-free cycles before the line is declared stuck; must be greater than `PERIOD`.
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `pwm_in`  in  1  asynchronous PWM input
- `duty_cycle`  out  8  reconstructed duty value
- `high_cnt`  out  CNT_W  high cycles in the last complete period
- `period_cnt`  out  CNT_W  cycles between the last two rising edges
- `valid`  out  1  one-cycle pulse on each capture or stuck event
- `period_err`  out  1  last captured period != `PERIOD`; held until the next capture
- `stuck`  out  1  no edge for `TIMEOUT` cycles; level signal

## Operation
- All outputs reset to 0 while `reset` is low. This takes effect immediately and asynchronously, including mid-measurement. The FSM returns to IDLE and all counters clear.
- Sync and edge detect:
  - Two-flop synchronizer `s1`→`s2`, followed by `prev`.
  - `rise` = `s2 & ~prev`; `fall` = `~s2 & prev`.
- FSM states: IDLE and MEAS.
- IDLE: waits for the first `rise`, then loads `per_ctr`=1 and `high_ctr`=1 and moves to MEAS. No `valid` is issued for the partial first cycle.
- MEAS, every cycle without a `rise`:
  - `per_ctr` += 1.
  - `high_ctr` += `s2`.
  - Both counters saturate at all-ones.
- MEAS, on `rise` (capture):
  - `period_cnt` ← `per_ctr`; `high_cnt` ← `high_ctr`, using the pre-update values.
  - Counters reload to 1.
  - `valid` pulses.
  - `period_err` ← (`per_ctr` != `PERIOD`).
  - `duty_cycle` ← min(`high_ctr`, 255), but only when the period matches; otherwise `duty_cycle` holds its previous value.
- Idle counter: clears on any `rise` or `fall`; otherwise increments, saturating at `TIMEOUT`.
- Stuck event, on reaching `TIMEOUT` in either state:
  - `stuck` ← 1.
  - `duty_cycle` ← 8'hFF if `s2` is high, 8'h00 if low.
  - `valid` pulses once; `period_err` ← 0.
  - FSM goes to IDLE and counters clear.
- `stuck` clears on the next edge of either polarity.
- Simultaneous timeout and edge in the same cycle: the edge wins and no stuck event occurs.
- A period longer than 2^CNT_W−1 saturates `period_cnt`, which results in `period_err`=1.

## Timing
- Latency: from a `pwm_in` transition, `s2` follows on the 2nd clk edge. Capture registers and `valid` update on the 3rd clk edge.
- `valid` is high for exactly one cycle per capture. For a matching waveform, consecutive pulses are `PERIOD` cycles apart.
- `duty_cycle`, `high_cnt`, `period_cnt`, and `period_err` are stable from the `valid` pulse until the next `valid`.
- After reset release, the first `valid` occurs at the second rising edge of `pwm_in` (plus 3 cycles), or at `TIMEOUT` if no edge arrives.
- No input handshake; there is no backpressure on outputs.

## Structure
- Shared package `pwm_pkg` holds `PWM_PERIOD`=256 and `DUTY_W`=8, so generator and capture agree on both.
- One sub-module, `pwm_sync`: two-flop synchronizer plus `prev` register, outputting `level`, `rise`, and `fall`. It uses the same `clk`/`reset` (async, active-low).
- The top level holds the FSM, the three counters, and the output registers.

## Test plan
- Drive the `pwm` generator with duty 64 into `pwm_in`. Expect `valid` every 256 cycles with `duty_cycle`=64, `high_cnt`=64, `period_cnt`=256, `period_err`=0.
- Change the generator duty from 64 to 192 mid-run. Expect at most one transitional capture, then `duty_cycle`=192 on every subsequent `valid`.
- Duty 255 (255 high / 1 low) → `duty_cycle`=255 with no `stuck`. Hold `pwm_in` constantly high → after 1024 edge-free cycles, one `valid` with `stuck`=1 and `duty_cycle`=8'hFF. Constant low → `duty_cycle`=8'h00.
- Bench-generated waveform with 50 high / 200 period → `valid` with `period_cnt`=200, `high_cnt`=50, `period_err`=1, and `duty_cycle` unchanged from the prior value.
- Assert `reset` low 100 cycles into a duty-64 measurement. All outputs go to 0 immediately. After release, no `valid` until the second rising edge, then `duty_cycle`=64.
- Arrange an edge on the exact cycle the idle counter would reach `TIMEOUT`. Expect `stuck` to stay 0 and measurement to continue.
